ddr_stream_wr_master: RTL and testbench

Write master that sits directly upstream of the DDR3 slave port and turns a 32-bit valid/ready sample stream into INCR write bursts of up to 256 beats. It accepts a start command (base address, word count), buffers incoming words in an internal FIFO, and issues a burst only when the whole burst is already buffered. This guarantees the write-data channel never stalls mid-burst. It runs in the DDR core clock domain (the slave's exported clock).

---
 rtl/ddr_stream_wr_master_pkg.sv | 16 +
 rtl/ddr_stream_wr_master_if.sv | 34 +++
 rtl/ddr_stream_wr_master_fifo.sv | 46 ++++
 rtl/ddr_stream_wr_master.sv | 146 ++++++++++++++
 tb/tb_ddr_stream_wr_master.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_stream_wr_master_pkg.sv
// Shared encodings and constants for the DDR stream write master.
package ddr_master_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // INCR bursts must not cross a 1 KB boundary: 256 words of 32 bits
  localparam int BOUNDARY_BEATS = 256;

  typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, RESP} state_e;
endpackage

// File: rtl/ddr_stream_wr_master_if.sv
// Write address / data / response channels between the stream master and the DDR slave port.
interface ddr_stream_wr_master_if #(parameter int ID_WIDTH = 4);
  logic [ID_WIDTH-1:0] MASTER_WR_ADDR_ID;
  logic [31:0]         MASTER_WR_ADDR;
  logic [7:0]          MASTER_WR_ADDR_LEN;
  logic [1:0]          MASTER_WR_ADDR_BURST;
  logic                MASTER_WR_ADDR_VALID;
  logic                MASTER_WR_ADDR_READY;
  logic [31:0]         MASTER_WR_DATA;
  logic [3:0]          MASTER_WR_STRB;
  logic                MASTER_WR_DATA_LAST;
  logic                MASTER_WR_DATA_VALID;
  logic                MASTER_WR_DATA_READY;
  logic [ID_WIDTH-1:0] MASTER_WR_BACK_ID;
  logic [1:0]          MASTER_WR_BACK_RESP;
  logic                MASTER_WR_BACK_VALID;
  logic                MASTER_WR_BACK_READY;

  modport master (
    output MASTER_WR_ADDR_ID, MASTER_WR_ADDR, MASTER_WR_ADDR_LEN, MASTER_WR_ADDR_BURST,
           MASTER_WR_ADDR_VALID, MASTER_WR_DATA, MASTER_WR_STRB, MASTER_WR_DATA_LAST,
           MASTER_WR_DATA_VALID, MASTER_WR_BACK_READY,
    input  MASTER_WR_ADDR_READY, MASTER_WR_DATA_READY, MASTER_WR_BACK_ID,
           MASTER_WR_BACK_RESP, MASTER_WR_BACK_VALID
  );

  modport slave (
    input  MASTER_WR_ADDR_ID, MASTER_WR_ADDR, MASTER_WR_ADDR_LEN, MASTER_WR_ADDR_BURST,
           MASTER_WR_ADDR_VALID, MASTER_WR_DATA, MASTER_WR_STRB, MASTER_WR_DATA_LAST,
           MASTER_WR_DATA_VALID, MASTER_WR_BACK_READY,
    output MASTER_WR_ADDR_READY, MASTER_WR_DATA_READY, MASTER_WR_BACK_ID,
           MASTER_WR_BACK_RESP, MASTER_WR_BACK_VALID
  );
endinterface

// File: rtl/ddr_stream_wr_master_fifo.sv
// First-word-fall-through FIFO with an occupancy count; head reads as 0 when empty.
module sync_fwft_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && (r_count != '0);
  assign o_count = r_count;
  assign o_dout  = (r_count != '0) ? r_mem[r_rd] : '0;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ddr_stream_wr_master.sv
// Stream-to-DDR write master: buffers a 32-bit stream and emits fully-buffered INCR bursts
// that never cross a 1 KB boundary, one burst outstanding at a time.
module ddr_stream_wr_master
  import ddr_master_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 512,
  parameter int WR_ID      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [23:0]          total_words,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  ddr_stream_wr_master_if.master m
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        r_state, w_next;
  logic [31:0]   r_ptr;
  logic [23:0]   r_remain, r_total, r_accepted;
  logic [8:0]    r_beats;
  logic [7:0]    r_len, r_beat_cnt;
  logic          r_busy, r_done, r_err;

  logic [CW-1:0] w_count;
  logic          w_full, w_start, w_push, w_pop, w_last, w_calc_ok;
  logic [31:0]   w_head;
  logic [8:0]    w_room, w_beats;
  logic          w_unused_id;

  assign w_unused_id = ^m.MASTER_WR_BACK_ID;

  // a start in the done cycle is dropped: r_done blocks it alongside r_busy
  assign w_start   = start && !r_busy && !r_done;
  assign s_ready   = r_busy && !w_full && (r_accepted != r_total);
  assign w_push    = s_valid && s_ready;
  assign w_pop     = (r_state == DATA) && m.MASTER_WR_DATA_READY;
  assign w_last    = (r_state == DATA) && (r_beat_cnt == r_len);
  assign w_room    = 9'(BOUNDARY_BEATS) - {1'b0, r_ptr[9:2]};
  assign w_beats   = (r_remain < 24'(w_room)) ? r_remain[8:0] : w_room;
  assign w_calc_ok = 32'(w_count) >= 32'(w_beats);

  sync_fwft_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (s_data),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_start && total_words != 24'd0) w_next = CALC;
      CALC: if (w_calc_ok) w_next = ADDR;
      ADDR: if (m.MASTER_WR_ADDR_READY) w_next = DATA;
      DATA: if (w_pop && w_last) w_next = RESP;
      RESP: if (m.MASTER_WR_BACK_VALID) w_next = (r_remain == 24'd0) ? IDLE : CALC;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_remain   <= '0;
      r_total    <= '0;
      r_accepted <= '0;
      r_beats    <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_push) r_accepted <= r_accepted + 24'd1;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_ptr      <= {base_addr[31:2], 2'b00};
            r_remain   <= total_words;
            r_total    <= total_words;
            r_accepted <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            // zero-length job: done next cycle, busy drops right after
            if (total_words == 24'd0) r_done <= 1'b1;
          end else if (r_busy) begin
            r_busy <= 1'b0;
          end
        end
        CALC: if (w_calc_ok) begin
          r_beats    <= w_beats;
          r_len      <= 8'(w_beats - 9'd1);
          r_beat_cnt <= '0;
        end
        DATA: if (w_pop) begin
          r_beat_cnt <= r_beat_cnt + 8'd1;
          if (w_last) begin
            r_ptr    <= r_ptr + {21'd0, r_beats, 2'b00};
            r_remain <= r_remain - {15'd0, r_beats};
          end
        end
        RESP: if (m.MASTER_WR_BACK_VALID) begin
          if (m.MASTER_WR_BACK_RESP != RESP_OKAY) r_err <= 1'b1;
          if (r_remain == 24'd0) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

  assign m.MASTER_WR_ADDR_ID    = ID_WIDTH'(WR_ID);
  assign m.MASTER_WR_ADDR       = r_ptr;
  assign m.MASTER_WR_ADDR_LEN   = r_len;
  assign m.MASTER_WR_ADDR_BURST = BURST_INCR;
  assign m.MASTER_WR_ADDR_VALID = (r_state == ADDR);
  assign m.MASTER_WR_DATA       = w_head;
  assign m.MASTER_WR_STRB       = 4'hF;
  assign m.MASTER_WR_DATA_LAST  = w_last;
  assign m.MASTER_WR_DATA_VALID = (r_state == DATA);
  assign m.MASTER_WR_BACK_READY = (r_state == RESP);
endmodule

// File: tb/tb_ddr_stream_wr_master.sv
// Bench for ddr_stream_wr_master: randomized stream/slave behaviour checked against a burst-split model.
module tb_ddr_stream_wr_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, busy, done, err, s_valid, s_ready;
  logic [31:0] base_addr, s_data;
  logic [23:0] total_words;

  ddr_stream_wr_master_if #(.ID_WIDTH(4)) bus();

  ddr_stream_wr_master #(.ID_WIDTH(4), .FIFO_DEPTH(512), .WR_ID(0)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total_words(total_words),
    .busy(busy), .done(done), .err(err), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m(bus)
  );

  int npass = 0, ntot = 0;
  logic [31:0] words[$], got_data[$], got_addr[$], exp_addr[$];
  logic [7:0]  got_len[$], exp_len[$];
  int cyc_done, first_av, done_lat, gap_err, last_err, buf_err, stab_err, accepted, timeout;
  logic busy_at_done, err_at_done, err_c1;

  task automatic fill_words(input int n, input bit seq);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(seq ? 32'(i) : $urandom);
  endtask

  // Expected burst list: split at 1 KB boundaries, at most 256 words each
  task automatic model_bursts(input logic [31:0] b, input int n);
    logic [31:0] ptr;
    int rem, room, bt;
    exp_addr.delete(); exp_len.delete();
    ptr = {b[31:2], 2'b00};
    rem = n;
    while (rem > 0) begin
      room = 256 - int'((ptr / 4) % 256);
      bt = (rem < room) ? rem : room;
      exp_addr.push_back(ptr);
      exp_len.push_back(8'(bt - 1));
      ptr = ptr + 32'(bt * 4);
      rem = rem - bt;
    end
  endtask

  function automatic int cmp_bursts();
    int mm = 0;
    if (got_addr.size() != exp_addr.size()) return 1000;
    for (int i = 0; i < got_addr.size(); i++)
      if (got_addr[i] !== exp_addr[i] || got_len[i] !== exp_len[i]) mm++;
    return mm;
  endfunction

  function automatic int cmp_words();
    int mm = 0;
    if (got_data.size() != words.size()) return 1000;
    for (int i = 0; i < words.size(); i++) if (got_data[i] !== words[i]) mm++;
    return mm;
  endfunction

  task automatic idle_inputs();
    s_valid = 0;
    bus.MASTER_WR_ADDR_READY = 0;
    bus.MASTER_WR_DATA_READY = 0;
    bus.MASTER_WR_BACK_VALID = 0;
  endtask

  // Drives one job and records what the slave side observes; decisions at negedge take effect next posedge
  task automatic run_job(input logic [31:0] b, input int n, input int rdy_pct, input int gap,
                         input logic [1:0] resp, input int abort_beats, input bit restart);
    int cyc, idx, pushed, popped, beat, bdelay, b_cyc;
    bit in_burst, pend_b, av_seen, hold, av_wait;
    logic [31:0] sv_addr;
    logic [7:0]  sv_len, cur_len;
    got_data.delete(); got_addr.delete(); got_len.delete();
    gap_err = 0; last_err = 0; buf_err = 0; stab_err = 0; timeout = 0;
    cyc_done = -1; first_av = -1; done_lat = -1; b_cyc = -1;
    idx = 0; pushed = 0; popped = 0; beat = 0; bdelay = 0;
    in_burst = 0; pend_b = 0; av_seen = 0; hold = 0; av_wait = 0;
    sv_addr = 0; sv_len = 0; cur_len = 0;
    @(negedge clk);
    start = 1; base_addr = b; total_words = 24'(n);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start = 0;
      if (cyc == 1) err_c1 = err;
      if (done) begin
        cyc_done = cyc; done_lat = cyc - b_cyc;
        busy_at_done = busy; err_at_done = err; accepted = pushed;
        idle_inputs();
        if (restart) begin start = 1; base_addr = 32'h8000; total_words = 24'd5; end
        break;
      end
      if (cyc > 20000) begin timeout = 1; accepted = pushed; idle_inputs(); break; end
      if (abort_beats >= 0 && popped >= abort_beats) begin accepted = pushed; break; end
      if (in_burst && !bus.MASTER_WR_DATA_VALID) gap_err++;
      if (av_wait && (!bus.MASTER_WR_ADDR_VALID || bus.MASTER_WR_ADDR !== sv_addr ||
                      bus.MASTER_WR_ADDR_LEN !== sv_len)) stab_err++;
      bus.MASTER_WR_ADDR_READY = ($urandom_range(99) < rdy_pct);
      if (bus.MASTER_WR_ADDR_VALID) begin
        if (first_av < 0) first_av = cyc;
        if (!av_seen) begin
          av_seen = 1;
          if (pushed - popped < int'(bus.MASTER_WR_ADDR_LEN) + 1) buf_err++;
        end
      end
      av_wait = bus.MASTER_WR_ADDR_VALID && !bus.MASTER_WR_ADDR_READY;
      sv_addr = bus.MASTER_WR_ADDR; sv_len = bus.MASTER_WR_ADDR_LEN;
      if (bus.MASTER_WR_ADDR_VALID && bus.MASTER_WR_ADDR_READY) begin
        got_addr.push_back(bus.MASTER_WR_ADDR);
        got_len.push_back(bus.MASTER_WR_ADDR_LEN);
        cur_len = bus.MASTER_WR_ADDR_LEN; beat = 0; in_burst = 1; av_seen = 0;
      end
      bus.MASTER_WR_DATA_READY = ($urandom_range(99) < rdy_pct);
      if (bus.MASTER_WR_DATA_VALID) begin
        if (bus.MASTER_WR_DATA_LAST !== (beat == int'(cur_len))) last_err++;
        if (bus.MASTER_WR_DATA_READY) begin
          got_data.push_back(bus.MASTER_WR_DATA);
          popped++;
          if (beat == int'(cur_len)) begin in_burst = 0; pend_b = 1; bdelay = $urandom_range(2); end
          beat++;
        end
      end
      if (pend_b && bdelay == 0) begin
        bus.MASTER_WR_BACK_VALID = 1; bus.MASTER_WR_BACK_RESP = resp;
        bus.MASTER_WR_BACK_ID = 4'($urandom);
        if (bus.MASTER_WR_BACK_READY) begin pend_b = 0; b_cyc = cyc; end
      end else begin
        bus.MASTER_WR_BACK_VALID = 0;
        if (pend_b) bdelay--;
      end
      // stream source keeps offering words past the job length to exercise the cutoff
      if (!hold) s_valid = (idx < n + 8) && (cyc % gap == 0);
      s_data = (idx < n) ? words[idx] : (32'hDEAD0000 ^ 32'(idx));
      if (s_valid && s_ready) begin idx++; pushed++; hold = 0; end
      else hold = s_valid;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    ntot++;
    if ({busy, done, err, s_ready, bus.MASTER_WR_ADDR_VALID, bus.MASTER_WR_DATA_VALID,
         bus.MASTER_WR_DATA_LAST, bus.MASTER_WR_BACK_READY} !== 8'h00)
      $display("FAIL reset_ctrl got %b want 00000000", {busy, done, err, s_ready,
        bus.MASTER_WR_ADDR_VALID, bus.MASTER_WR_DATA_VALID, bus.MASTER_WR_DATA_LAST,
        bus.MASTER_WR_BACK_READY});
    else npass++;
    ntot++;
    if ({bus.MASTER_WR_ADDR, bus.MASTER_WR_ADDR_LEN, bus.MASTER_WR_DATA} !== 72'h0)
      $display("FAIL reset_bus addr=%h len=%h data=%h want 0", bus.MASTER_WR_ADDR,
               bus.MASTER_WR_ADDR_LEN, bus.MASTER_WR_DATA);
    else npass++;
    ntot++;
    if ({bus.MASTER_WR_ADDR_ID, bus.MASTER_WR_ADDR_BURST, bus.MASTER_WR_STRB} !== {4'h0, 2'b01, 4'hF})
      $display("FAIL const_outs id=%h burst=%b strb=%h want 0/01/f", bus.MASTER_WR_ADDR_ID,
               bus.MASTER_WR_ADDR_BURST, bus.MASTER_WR_STRB);
    else npass++;
    rst = 0;
  endtask

  task automatic test_single_burst();
    fill_words(16, 1);
    model_bursts(32'h1000, 16);
    run_job(32'h1000, 16, 100, 1, 2'b00, -1, 0);
    ntot++; if (timeout !== 0) $display("FAIL single_timeout got %0d want 0", timeout); else npass++;
    ntot++; if (cmp_bursts() !== 0) $display("FAIL single_bursts mism=%0d got_n=%0d want_n=%0d", cmp_bursts(), got_addr.size(), exp_addr.size()); else npass++;
    ntot++; if (cmp_words() !== 0) $display("FAIL single_data mism=%0d got_n=%0d want 16", cmp_words(), got_data.size()); else npass++;
    ntot++; if (last_err !== 0) $display("FAIL single_last errs=%0d want 0", last_err); else npass++;
    ntot++; if (done_lat !== 1) $display("FAIL single_done_lat got %0d want 1", done_lat); else npass++;
    ntot++; if ({err_at_done, busy_at_done} !== 2'b00) $display("FAIL single_err_busy got %b want 00", {err_at_done, busy_at_done}); else npass++;
    ntot++; if (accepted !== 16) $display("FAIL single_accepted got %0d want 16", accepted); else npass++;
    ntot++; if (first_av < 2) $display("FAIL single_first_av got %0d want >=2", first_av); else npass++;
  endtask

  task automatic test_boundary_split();
    fill_words(8, 0);
    model_bursts(32'h13F0, 8);
    run_job(32'h13F0, 8, 70, 1, 2'b00, -1, 0);
    ntot++; if (timeout !== 0) $display("FAIL split_timeout got %0d want 0", timeout); else npass++;
    ntot++; if (cmp_bursts() !== 0) $display("FAIL split_bursts mism=%0d got_n=%0d want_n=%0d", cmp_bursts(), got_addr.size(), exp_addr.size()); else npass++;
    ntot++; if (cmp_words() !== 0) $display("FAIL split_data mism=%0d", cmp_words()); else npass++;
    ntot++; if (stab_err + last_err !== 0) $display("FAIL split_stable_last got %0d want 0", stab_err + last_err); else npass++;
  endtask

  task automatic test_large_backpressure();
    fill_words(600, 0);
    model_bursts(32'h0, 600);
    run_job(32'h0, 600, 50, 1, 2'b00, -1, 0);
    ntot++; if (timeout !== 0) $display("FAIL large_timeout got %0d want 0", timeout); else npass++;
    ntot++; if (cmp_bursts() !== 0) $display("FAIL large_bursts mism=%0d got_n=%0d want_n=%0d", cmp_bursts(), got_addr.size(), exp_addr.size()); else npass++;
    ntot++; if (cmp_words() !== 0) $display("FAIL large_data mism=%0d got_n=%0d", cmp_words(), got_data.size()); else npass++;
    ntot++; if (gap_err !== 0) $display("FAIL large_gaps got %0d want 0", gap_err); else npass++;
    ntot++; if (accepted !== 600) $display("FAIL large_accepted got %0d want 600", accepted); else npass++;
    ntot++; if (last_err + stab_err !== 0) $display("FAIL large_last_stable got %0d want 0", last_err + stab_err); else npass++;
  endtask

  task automatic test_starvation();
    fill_words(256, 0);
    model_bursts(32'h4000, 256);
    run_job(32'h4000, 256, 100, 4, 2'b00, -1, 0);
    ntot++; if (timeout !== 0) $display("FAIL starve_timeout got %0d want 0", timeout); else npass++;
    ntot++; if (buf_err !== 0) $display("FAIL starve_prebuffer got %0d want 0", buf_err); else npass++;
    ntot++; if (gap_err !== 0) $display("FAIL starve_gaps got %0d want 0", gap_err); else npass++;
    ntot++; if (cmp_bursts() + cmp_words() !== 0) $display("FAIL starve_content mism=%0d want 0", cmp_bursts() + cmp_words()); else npass++;
  endtask

  task automatic test_error_zero_len();
    fill_words(0, 0);
    run_job(32'h100, 0, 100, 1, 2'b00, -1, 0);
    ntot++; if (cyc_done !== 1) $display("FAIL zero_done_cyc got %0d want 1", cyc_done); else npass++;
    ntot++; if (first_av !== -1) $display("FAIL zero_no_addr got first_av=%0d want -1", first_av); else npass++;
    fill_words(4, 0);
    run_job(32'h200, 4, 100, 1, 2'b10, -1, 0);
    ntot++; if (err_at_done !== 1'b1) $display("FAIL err_set got %b want 1", err_at_done); else npass++;
    @(negedge clk);
    ntot++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else npass++;
    fill_words(4, 0);
    run_job(32'h300, 4, 100, 1, 2'b00, -1, 0);
    ntot++; if (err_c1 !== 1'b0) $display("FAIL err_clear got %b want 0", err_c1); else npass++;
    ntot++; if (err_at_done !== 1'b0) $display("FAIL err_ok_job got %b want 0", err_at_done); else npass++;
  endtask

  task automatic test_back_to_back();
    fill_words(8, 0);
    run_job(32'h500, 8, 100, 1, 2'b00, -1, 1);
    @(negedge clk);
    start = 0;
    ntot++; if (busy !== 1'b0) $display("FAIL start_in_done_ignored busy=%b want 0", busy); else npass++;
    fill_words(12, 0);
    model_bursts(32'h600, 12);
    run_job(32'h600, 12, 100, 1, 2'b00, -1, 0);
    ntot++; if (cmp_bursts() + cmp_words() !== 0) $display("FAIL b2b_content mism=%0d want 0", cmp_bursts() + cmp_words()); else npass++;
  endtask

  task automatic test_reset_mid_burst();
    fill_words(64, 0);
    run_job(32'h2000, 64, 100, 1, 2'b00, 10, 0);
    #2 rst = 1;
    #1;
    ntot++;
    if ({busy, done, err, s_ready, bus.MASTER_WR_ADDR_VALID, bus.MASTER_WR_DATA_VALID,
         bus.MASTER_WR_DATA_LAST, bus.MASTER_WR_BACK_READY} !== 8'h00)
      $display("FAIL midrst_ctrl got %b want 00000000", {busy, done, err, s_ready,
        bus.MASTER_WR_ADDR_VALID, bus.MASTER_WR_DATA_VALID, bus.MASTER_WR_DATA_LAST,
        bus.MASTER_WR_BACK_READY});
    else npass++;
    ntot++;
    if ({bus.MASTER_WR_ADDR, bus.MASTER_WR_ADDR_LEN, bus.MASTER_WR_DATA} !== 72'h0)
      $display("FAIL midrst_bus addr=%h len=%h data=%h want 0", bus.MASTER_WR_ADDR,
               bus.MASTER_WR_ADDR_LEN, bus.MASTER_WR_DATA);
    else npass++;
    idle_inputs();
    @(negedge clk); @(negedge clk);
    rst = 0;
    fill_words(20, 0);
    model_bursts(32'h3000, 20);
    run_job(32'h3000, 20, 80, 1, 2'b00, -1, 0);
    ntot++; if (timeout !== 0) $display("FAIL postrst_timeout got %0d want 0", timeout); else npass++;
    ntot++; if (cmp_bursts() + cmp_words() !== 0) $display("FAIL postrst_content mism=%0d want 0", cmp_bursts() + cmp_words()); else npass++;
  endtask

  task automatic test_random();
    for (int j = 0; j < 3; j++) begin
      logic [31:0] b;
      int n, pct;
      b = $urandom; n = $urandom_range(300, 1); pct = $urandom_range(100, 30);
      fill_words(n, 0);
      model_bursts(b, n);
      run_job(b, n, pct, 1, 2'b00, -1, 0);
      ntot++;
      if (timeout !== 0 || cmp_bursts() + cmp_words() !== 0)
        $display("FAIL random_job%0d base=%h n=%0d timeout=%0d mism=%0d want 0", j, b, n,
                 timeout, cmp_bursts() + cmp_words());
      else npass++;
    end
  endtask

  initial begin
    rst = 0; start = 0; base_addr = 0; total_words = 0; s_valid = 0; s_data = 0;
    bus.MASTER_WR_ADDR_READY = 0; bus.MASTER_WR_DATA_READY = 0;
    bus.MASTER_WR_BACK_VALID = 0; bus.MASTER_WR_BACK_RESP = 0; bus.MASTER_WR_BACK_ID = 0;
    #2 rst = 1;
    test_reset();
    test_single_burst();
    test_boundary_split();
    test_large_backpressure();
    test_starvation();
    test_error_zero_len();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
